// File: rtl/ula_pkg.sv
// ula_pkg: ULAopcode values shared with the ALU-control decoder,
// the mul/div FSM state type and the default datapath width.
package ula_pkg;
   localparam int ULA_WIDTH = 32;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULT = 4'b1000;
   localparam logic [3:0] OP_DIV  = 4'b1001;
   localparam logic [3:0] OP_MFLO = 4'b1010;
   localparam logic [3:0] OP_MFHI = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_XOR  = 4'b1101;
   localparam logic [3:0] OP_LUI  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } md_state_t;
endpackage

// File: rtl/ula_muldiv_seq.sv
// ula_muldiv_seq: iterative signed multiplier / restoring divider
// owning HI/LO; magnitudes are processed, signs fixed up in FIN.
module ula_muldiv_seq
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH,
   parameter int ITER  = ULA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go_mul,
   input  logic             go_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             idle,
   output logic             run,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   md_state_t          state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   p;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   p_n;
   logic [WIDTH-1:0]   q_n;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rs;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign idle  = (state == IDLE);
   assign run   = (state == RUN);
   assign prod  = neg_q ? -{p, q} : {p, q};

   // One iteration: shift-add for MULT, shift-subtract for DIV
   always_comb begin
      sum  = {1'b0, p} + (q[0] ? {1'b0, m} : '0);
      rs   = {p, q[WIDTH-1]};
      diff = rs - {1'b0, m};
      if (is_div) begin
         if (diff[WIDTH]) begin
            p_n = rs[WIDTH-1:0];
            q_n = {q[WIDTH-2:0], 1'b0};
         end else begin
            p_n = diff[WIDTH-1:0];
            q_n = {q[WIDTH-2:0], 1'b1};
         end
      end else begin
         p_n = sum[WIDTH:1];
         q_n = {sum[0], q[WIDTH-1:1]};
      end
   end

   // FSM, iteration counter, working registers and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         a_raw   <= '0;
         m       <= '0;
         p       <= '0;
         q       <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         divzero <= 1'b0;
      end else begin
         done    <= 1'b0;
         divzero <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go_mul || go_div) begin
                  is_div <= go_div;
                  neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                  neg_r  <= a[WIDTH-1];
                  dz     <= (b == '0);
                  a_raw  <= a;
                  m      <= b_mag;
                  q      <= a_mag;
                  p      <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               p   <= p_n;
               q   <= q_n;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state   <= FIN;
                  done    <= 1'b1;
                  divzero <= is_div & dz;
               end
            end
            FIN: begin
               if (!is_div) begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end else if (dz) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= neg_r ? -p : p;
                  lo <= neg_q ? -q : q;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/ula_seq.sv
// ula_seq: combinational ALU plus sequential mul/div with Stall.
// Divider is present only when ULA_DIV_EN is defined.
module ula_seq
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH,
   parameter int ITER  = ULA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ULAopcode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             Stall,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   logic             idle;
   logic             run;
   logic             go_mul;
   logic             go_div;
   logic             is_mfx;
   logic [WIDTH-1:0] bn;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;

   assign is_mfx = (ULAopcode == OP_MFLO) || (ULAopcode == OP_MFHI);
   assign go_mul = start & idle & (ULAopcode == OP_MULT);
`ifdef ULA_DIV_EN
   assign go_div = start & idle & (ULAopcode == OP_DIV);
`else
   assign go_div = 1'b0;
`endif
   assign Stall = run | go_mul | go_div | (start & ~idle & is_mfx);

   assign sum = A + B;
   assign dif = A - B;
   assign bn  = ~B + WIDTH'(1);

   // Single-cycle ALU result and ADD/SUB overflow
   always_comb begin
      Result   = '0;
      Overflow = 1'b0;
      unique case (ULAopcode)
         OP_ADD: begin
            Result   = sum;
            Overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                       (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            Result   = dif;
            Overflow = (A[WIDTH-1] == bn[WIDTH-1]) &&
                       (dif[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  Result = A & B;
         OP_OR:   Result = A | B;
         OP_NOR:  Result = ~(A | B);
         OP_XOR:  Result = A ^ B;
         OP_SLT:  Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_LUI:  Result = {B[15:0], {(WIDTH-16){1'b0}}};
         OP_MFLO: Result = LO;
         OP_MFHI: Result = HI;
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

   ula_muldiv_seq #(
      .WIDTH (WIDTH),
      .ITER  (ITER)
   ) u_md (
      .clk     (clk),
      .rst_n   (rst_n),
      .go_mul  (go_mul),
      .go_div  (go_div),
      .a       (A),
      .b       (B),
      .idle    (idle),
      .run     (run),
      .done    (Done),
      .divzero (DivZero),
      .hi      (HI),
      .lo      (LO)
   );
endmodule
